// File: rtl/bubble_sort.sv
// Sequential bubble sorter: one compare/swap per clock over N unsigned WIDTH-bit elements.
// Define BUBBLE_SORT_EARLY_EXIT_EN to finish after the first pass that performs no swaps.
module bubble_sort #(
    parameter int unsigned N     = 5,
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   in_array,
    output logic                 busy,
    output logic                 done,
    output logic [N*WIDTH-1:0]   out_array
);

    localparam int unsigned IDX_W = (N > 2) ? $clog2(N) : 1;
    // Index of the last pass, which is also the last j of pass 0.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((N >= 2) ? N - 2 : 0);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_SORT = 1'b1;

    logic               state_q, state_d;
    logic [N*WIDTH-1:0] work_q, work_d;
    logic [N*WIDTH-1:0] out_q, out_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [IDX_W-1:0]   pass_q, pass_d;
    logic               done_q, done_d;

    logic [N*WIDTH-1:0] cmp_work;
    logic               cmp_swap;
    logic               pass_end;
    logic               last_pass;
    logic               finish;

    // Compare/swap the pair selected by j; equal values are never swapped.
    always_comb begin
        cmp_work = work_q;
        cmp_swap = 1'b0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (j_q == IDX_W'(i) &&
                work_q[i*WIDTH +: WIDTH] > work_q[(i+1)*WIDTH +: WIDTH]) begin
                cmp_work[i*WIDTH +: WIDTH]     = work_q[(i+1)*WIDTH +: WIDTH];
                cmp_work[(i+1)*WIDTH +: WIDTH] = work_q[i*WIDTH +: WIDTH];
                cmp_swap                       = 1'b1;
            end
        end
    end

    assign pass_end  = (j_q == LAST_IDX - pass_q);
    assign last_pass = (pass_q == LAST_IDX);

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    logic swapped_pass_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            swapped_pass_q <= 1'b0;
        end else if (state_q == STATE_IDLE || pass_end) begin
            swapped_pass_q <= 1'b0;
        end else begin
            swapped_pass_q <= swapped_pass_q | cmp_swap;
        end
    end

    assign finish = pass_end && (last_pass || !(swapped_pass_q || cmp_swap));
`else
    assign finish = pass_end && last_pass;
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        j_d     = j_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (start) begin
                    work_d  = in_array;
                    j_d     = '0;
                    pass_d  = '0;
                    state_d = STATE_SORT;
                end
            end
            STATE_SORT: begin
                work_d = cmp_work;
                if (finish) begin
                    out_d   = cmp_work;
                    done_d  = 1'b1;
                    state_d = STATE_IDLE;
                end else if (pass_end) begin
                    j_d    = '0;
                    pass_d = pass_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            work_q  <= '0;
            out_q   <= '0;
            j_q     <= '0;
            pass_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            j_q     <= j_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == STATE_SORT);
    assign done      = done_q;
    assign out_array = out_q;

    assert property (@(posedge clk) disable iff (rst) !(done && busy));

endmodule

// File: tb/tb_bubble_sort.sv
// Directed and random checks of bubble_sort (N=5, WIDTH=8) against hand-computed results.
module tb_bubble_sort;

    localparam int N = 5;
    localparam int W = 8;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    localparam int LAT_MIXED  = 9;
    localparam int LAT_SORTED = 4;
`else
    localparam int LAT_MIXED  = 10;
    localparam int LAT_SORTED = 10;
`endif
    localparam int LAT_FULL = 10;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N*W-1:0] in_array;
    logic           busy;
    logic           done;
    logic [N*W-1:0] out_array;

    int vectors;
    int miscompares;
    int overlap;

    bubble_sort #(.N(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_array (in_array),
        .busy     (busy),
        .done     (done),
        .out_array(out_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pack5(input int a, input int b, input int c,
                                             input int d, input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Called #1 after a clock edge with the sorter idle; returns #1 after the done edge.
    task automatic run_sort(input logic [N*W-1:0] vec, output logic [N*W-1:0] res,
                            output int lat);
        in_array = vec;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done && busy) overlap++;
        end
        res = out_array;
    endtask

    task automatic test_reset();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        vectors++;
        if (out_array !== '0) begin
            miscompares++;
            $display("FAIL reset_out: got %h want 0", out_array);
        end
    endtask

    task automatic test_sort(input string name, input logic [N*W-1:0] vec,
                             input logic [N*W-1:0] exp, input int exp_lat);
        logic [N*W-1:0] res;
        int lat;
        run_sort(vec, res, lat);
        vectors++;
        if (res !== exp) begin
            miscompares++;
            $display("FAIL %s_result: got %h want %h", name, res, exp);
        end
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_at_done: got %b want 0", name, busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done_width: got %b want 0", name, done);
        end
        vectors++;
        if (out_array !== exp) begin
            miscompares++;
            $display("FAIL %s_hold: got %h want %h", name, out_array, exp);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        logic [N*W-1:0] res;
        int lat;
        in_array = pack5(90, 80, 70, 60, 50);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_busy: got %b want 0", busy);
        end
        vectors++;
        if (out_array !== '0) begin
            miscompares++;
            $display("FAIL midrst_out: got %h want 0", out_array);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", seen);
        end
        run_sort(pack5(4, 2, 9, 1, 6), res, lat);
        vectors++;
        if (res !== pack5(1, 2, 4, 6, 9)) begin
            miscompares++;
            $display("FAIL midrst_resort: got %h want %h", res, pack5(1, 2, 4, 6, 9));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        in_array = pack5(9, 8, 7, 6, 5);
        start    = 1'b1;
        @(posedge clk);
        #1;
        in_array = pack5(50, 40, 30, 20, 10);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== LAT_FULL) begin
            miscompares++;
            $display("FAIL held_start_latency: got %0d want %0d", lat, LAT_FULL);
        end
        vectors++;
        if (out_array !== pack5(5, 6, 7, 8, 9)) begin
            miscompares++;
            $display("FAIL held_start_result: got %h want %h", out_array, pack5(5, 6, 7, 8, 9));
        end
        // start is still high in the done cycle, so this edge launches a new sort.
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy %b want 1", busy);
        end
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== LAT_FULL) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d want %0d", lat, LAT_FULL);
        end
        vectors++;
        if (out_array !== pack5(10, 20, 30, 40, 50)) begin
            miscompares++;
            $display("FAIL b2b_result: got %h want %h", out_array, pack5(10, 20, 30, 40, 50));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int v [N];
        logic [N*W-1:0] vec, exp, res;
        int lat, t;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = (it % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            end
            vec = pack5(v[0], v[1], v[2], v[3], v[4]);
            for (int a = 1; a < N; a++) begin
                for (int b = a; b > 0 && v[b-1] > v[b]; b--) begin
                    t = v[b]; v[b] = v[b-1]; v[b-1] = t;
                end
            end
            exp = pack5(v[0], v[1], v[2], v[3], v[4]);
            run_sort(vec, res, lat);
            vectors++;
            if (res !== exp) begin
                miscompares++;
                $display("FAIL rand%0d_result: got %h want %h (in %h)", it, res, exp, vec);
            end
            vectors++;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            if (lat < 4 || lat > LAT_FULL) begin
`else
            if (lat !== LAT_FULL) begin
`endif
                miscompares++;
                $display("FAIL rand%0d_latency: got %0d want <= %0d", it, lat, LAT_FULL);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_done_width: got %b want 0", it, done);
            end
        end
        vectors++;
        if (overlap !== 0) begin
            miscompares++;
            $display("FAIL done_busy_overlap: got %0d cycles want 0", overlap);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        overlap     = 0;
        rst         = 1'b1;
        start       = 1'b0;
        in_array    = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_sort("mixed", pack5(30, 10, 50, 20, 40), pack5(10, 20, 30, 40, 50), LAT_MIXED);
        test_sort("sorted", pack5(1, 2, 3, 4, 5), pack5(1, 2, 3, 4, 5), LAT_SORTED);
        test_sort("reverse", pack5(255, 200, 100, 50, 0), pack5(0, 50, 100, 200, 255), LAT_FULL);
        test_sort("dups", pack5(7, 3, 7, 3, 0), pack5(0, 3, 3, 7, 7), LAT_FULL);
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
